tick_gen: RTL and testbench
===========================

# tick_gen

Programmable prescaler that produces the one-cycle `en` tick pulses consumed by `timer`. It sits directly upstream of `timer` and replaces hand-driven enables with a clock-derived tick of configurable period. It has run/hold/clear control, a run-time divisor load handshake, and an optional burst mode that stops after a fixed number of ticks.

## Interface
- `DIV`, default 4: divisor in effect after reset, in clk cycles per tick.
- `WIDTH`, default 8: width of the divisor, the counter and the burst length.
- `clk` in 1: clock; all state updates on the rising edge.
- `r` in 1: reset, asynchronous, active-low.
- `start` in 1: run request, sampled on each edge.
- `stop` in 1: hold request, sampled on each edge.
- `clr` in 1: synchronous clear to IDLE.
- `div_in` in WIDTH: new divisor value.
- `div_load` in 1: divisor load valid.
- `div_ready` out 1: divisor load ready.
- `en` out 1: tick, registered, one cycle wide; connects to `timer.en`.
- `running` out 1: high while in RUN.
- `burst_len` in WIDTH: burst length; present only with `TICK_GEN_BURST_EN`.
- `burst_done` out 1: one-cycle pulse at burst completion; present only with `TICK_GEN_BURST_EN`.

## Operation
- **States:** IDLE, RUN, HOLD.
- **Reset values:** state=IDLE, cnt=0, div_q=DIV, pending=0, en=0, running=0, div_ready=1, burst_done=0.
- **IDLE:**
  - `start` → RUN with cnt=0.
  - `stop` is ignored.
- **RUN:**
  - cnt increments each cycle.
  - When cnt==eff_div-1: cnt←0 and en←1. This is the tick boundary.
  - `stop` → HOLD; cnt is kept.
- **HOLD:**
  - cnt is frozen and en=0.
  - `start` → RUN; counting resumes from the kept cnt.
- **`clr`:**
  - From any state: → IDLE, cnt←0, pending←0, en←0.
  - Has priority over start, stop and tick.
- **start and stop together:** stop wins. RUN→HOLD; IDLE stays IDLE; HOLD stays HOLD.
- **Effective divisor:** eff_div = (div_q==0) ? 1 : div_q. A divisor of 0 or 1 gives a tick every cycle.
- **Divisor load:**
  - A transfer happens when div_load && div_ready.
  - In IDLE or HOLD: div_q←div_in immediately, and cnt←0.
  - In RUN: div_in goes into a shadow register and pending←1. div_q takes the shadow value at the next tick boundary or on entry to HOLD/IDLE. pending then clears.
  - div_ready = !pending.
  - A load and `clr` in the same cycle: the load is dropped.
- **Arithmetic:** counter compare and increment are WIDTH-bit unsigned. cnt never exceeds eff_div-1.

## Timing
- `start` sampled at edge k with state IDLE:
  - running=1 after edge k.
  - First en high after edge k+D, where D = eff_div.
  - Then en is high once every D cycles, for exactly one cycle each time.
- Resume from HOLD with kept cnt=c: first tick D-c cycles after the `start` edge.
- `stop` sampled on the same edge as a tick boundary: the tick is still issued (en=1 for that cycle), then cnt=0 in HOLD.
- `r` asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge.
- Latency from `div_load` handshake to the new period:
  - In IDLE/HOLD: the next RUN.
  - In RUN: the period following the next tick.

## Configuration
- **`TICK_GEN_BURST_EN` defined:**
  - A burst counter is cleared on the IDLE→RUN transition and incremented on every tick.
  - When the tick count reaches burst_len: en=1 for that final tick, burst_done=1 in the same cycle, state→IDLE, cnt←0.
  - burst_len=0 means unlimited.
  - HOLD preserves the burst count.
- **Undefined:**
  - Free-running; the state leaves RUN only via `stop`, `clr` or reset.
  - `burst_len` and `burst_done` ports are absent.

## Test plan
- **Reset:**
  - Stimulus: r=0 mid-RUN with DIV=4.
  - Required: en=0, running=0 and div_ready=1 immediately. After release and a start pulse, first en 4 cycles later.
- **Period:**
  - Stimulus: DIV=4, start for one cycle, then run for 48 cycles, feeding `timer` with n=12, counter_bits=4.
  - Required: exactly 12 en pulses spaced 4 cycles apart. timer `done` asserts on the 12th.
- **Hold/resume:**
  - Stimulus: DIV=5; stop when cnt=2, hold 7 cycles, then start.
  - Required: no en during HOLD. Next en 3 cycles after resume.
- **Divisor load in RUN:**
  - Stimulus: div=4, load div_in=2 mid-period.
  - Required: div_ready=0 until the next tick. Spacing after that tick is 2 cycles.
- **Edge cases:**
  - Stimulus 1: div_in=0. Required: en every cycle.
  - Stimulus 2: start and stop in the same cycle from RUN. Required: HOLD.
  - Stimulus 3: clr together with div_load. Required: IDLE, div_q unchanged.
- **Burst (`TICK_GEN_BURST_EN`):**
  - Stimulus: burst_len=3, DIV=2.
  - Required: 3 ticks, burst_done together with the 3rd, then running=0.

Source files
------------

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable prescaler emitting one-cycle en ticks for timer
//
// Optional build macro: TICK_GEN_BURST_EN (adds burst_len / burst_done and
// the stop-after-N-ticks behaviour; without it the generator free-runs).
//
// Ports:
//   clk         clock, rising-edge
//   r           asynchronous active-low reset
//   start       run request (IDLE/HOLD -> RUN)
//   stop        hold request (RUN -> HOLD), wins over start
//   clr         synchronous clear to IDLE, highest priority
//   div_in      new divisor value
//   div_load    divisor load valid
//   div_ready   divisor load ready (low while a RUN-time load is pending)
//   en          registered one-cycle tick
//   running     high while in RUN
//   burst_len   ticks per burst, 0 = unlimited    (TICK_GEN_BURST_EN only)
//   burst_done  pulse with the final burst tick   (TICK_GEN_BURST_EN only)

module tick_gen #(
    parameter int DIV   = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ready,
    output logic             en,
`ifdef TICK_GEN_BURST_EN
    input  logic [WIDTH-1:0] burst_len,
    output logic             burst_done,
`endif
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV);

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] div_q, div_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic             pending, pending_n;
    logic             en_n;
    logic             xfer;
    logic             tick;
`ifdef TICK_GEN_BURST_EN
    logic [WIDTH-1:0] bcnt, bcnt_n;
    logic             bdone_n;
`endif

    // Last counter value of a period for divisor d; 0 and 1 both tick every cycle.
    function automatic logic [WIDTH-1:0] last_of(input logic [WIDTH-1:0] d);
        return (d == '0) ? '0 : d - WIDTH'(1);
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_n     = div_q;
        shadow_n  = shadow;
        pending_n = pending;
        en_n      = 1'b0;
        tick      = 1'b0;
        xfer      = div_load && !pending && !clr;
`ifdef TICK_GEN_BURST_EN
        bcnt_n    = bcnt;
        bdone_n   = 1'b0;
`endif
        if (clr) begin
            // A pending shadow divisor is committed on the way out of RUN;
            // a load offered in this same cycle is dropped (xfer is low).
            state_n   = IDLE;
            cnt_n     = '0;
            pending_n = 1'b0;
            if (pending) begin
                div_n = shadow;
            end
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (xfer) begin
                        div_n = div_in;
                    end
                    if (start && !stop) begin
                        state_n = RUN;
`ifdef TICK_GEN_BURST_EN
                        bcnt_n  = '0;
`endif
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        div_n = div_in;
                        cnt_n = '0;
                    end
                    if (start && !stop) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    // >= rather than == so a shrunken divisor can never
                    // leave the counter stranded above its wrap point.
                    tick = (cnt >= last_of(div_q));
                    if (tick) begin
                        en_n  = 1'b1;
                        cnt_n = '0;
                        if (pending) begin
                            div_n     = shadow;
                            pending_n = 1'b0;
                        end
`ifdef TICK_GEN_BURST_EN
                        bcnt_n = bcnt + WIDTH'(1);
                        if ((burst_len != '0) && (bcnt_n == burst_len)) begin
                            bdone_n = 1'b1;
                            state_n = IDLE;
                        end
`endif
                    end else begin
                        cnt_n = cnt + WIDTH'(1);
                    end

                    if (stop && (state_n == RUN)) begin
                        state_n = HOLD;
                        if (!tick) begin
                            cnt_n = cnt;
                        end
                    end

                    if (state_n != RUN) begin
                        // Leaving RUN: divisor changes take effect now, and
                        // the kept count is pulled back into range.
                        if (pending) begin
                            div_n = shadow;
                        end
                        if (xfer) begin
                            div_n = div_in;
                        end
                        pending_n = 1'b0;
                        if (cnt_n > last_of(div_n)) begin
                            cnt_n = '0;
                        end
                    end else if (xfer) begin
                        shadow_n  = div_in;
                        pending_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= DIV_RST;
            shadow  <= '0;
            pending <= 1'b0;
            en      <= 1'b0;
`ifdef TICK_GEN_BURST_EN
            bcnt       <= '0;
            burst_done <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_q   <= div_n;
            shadow  <= shadow_n;
            pending <= pending_n;
            en      <= en_n;
`ifdef TICK_GEN_BURST_EN
            bcnt       <= bcnt_n;
            burst_done <= bdone_n;
`endif
        end
    end

    assign running   = (state == RUN);
    assign div_ready = !pending;

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - self-checking bench for tick_gen

module tb_tick_gen;

    localparam int W    = 8;
    localparam int DIVP = 4;

    logic         clk      = 1'b0;
    logic         r        = 1'b0;
    logic         start    = 1'b0;
    logic         stop     = 1'b0;
    logic         clr      = 1'b0;
    logic [W-1:0] div_in   = '0;
    logic         div_load = 1'b0;
    logic         div_ready;
    logic         en;
    logic         running;
`ifdef TICK_GEN_BURST_EN
    logic [W-1:0] burst_len = '0;
    logic         burst_done;
`endif

    int tests = 0;
    int fails = 0;

    tick_gen #(.DIV(DIVP), .WIDTH(W)) dut (
        .clk       (clk),
        .r         (r),
        .start     (start),
        .stop      (stop),
        .clr       (clr),
        .div_in    (div_in),
        .div_load  (div_load),
        .div_ready (div_ready),
        .en        (en),
`ifdef TICK_GEN_BURST_EN
        .burst_len (burst_len),
        .burst_done(burst_done),
`endif
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the absolute edge number of the next tick
    // and the phase kept across HOLD, rather than a running counter.
    int           e         = 0;
    int           m_state   = 0;     // 0 idle, 1 run, 2 hold
    int           next_tick = 0;
    int           kept      = 0;
    int           m_div     = DIVP;
    int           m_shadow  = 0;
    bit           m_pend    = 0;
    bit           m_en      = 0;
    bit           m_bdone   = 0;
    logic [W-1:0] m_bcnt    = '0;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    initial forever begin
        @(posedge clk or negedge r);
        if (!r) begin
            e = 0; m_state = 0; next_tick = 0; kept = 0; m_div = DIVP;
            m_pend = 0; m_en = 0; m_bdone = 0; m_bcnt = '0;
        end else begin
            bit ld;
            bit tk;
            int d;
            e++;
            m_en    = 0;
            m_bdone = 0;
            ld = div_load && !m_pend;
            if (clr) begin
                if (m_pend) m_div = m_shadow;
                m_pend  = 0;
                m_state = 0;
            end else if (m_state == 0) begin
                if (ld) m_div = int'(div_in);
                if (start && !stop) begin
                    m_state   = 1;
                    m_bcnt    = '0;
                    next_tick = e + eff(m_div);
                end
            end else if (m_state == 2) begin
                if (ld) begin
                    m_div = int'(div_in);
                    kept  = 0;
                end
                if (start && !stop) begin
                    m_state   = 1;
                    next_tick = e + eff(m_div) - kept;
                end
            end else begin
                d  = eff(m_div);
                tk = (e == next_tick);
                if (tk) begin
                    m_en = 1;
                    if (m_pend) begin
                        m_div  = m_shadow;
                        m_pend = 0;
                    end
                    next_tick = e + eff(m_div);
                    m_bcnt    = m_bcnt + 1'b1;
`ifdef TICK_GEN_BURST_EN
                    if (burst_len != 0 && m_bcnt == burst_len) begin
                        m_bdone = 1;
                        m_state = 0;
                    end
`endif
                end
                if (stop && m_state == 1) begin
                    m_state = 2;
                    kept    = tk ? 0 : d - 1 - (next_tick - e);
                end
                if (m_state != 1) begin
                    if (m_pend) m_div = m_shadow;
                    if (ld) m_div = int'(div_in);
                    m_pend = 0;
                    if (kept > eff(m_div) - 1) kept = 0;
                end else if (ld) begin
                    m_shadow = int'(div_in);
                    m_pend   = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (r) begin
            chk("model_en", int'(en), int'(m_en));
            chk("model_running", int'(running), (m_state == 1) ? 1 : 0);
            chk("model_div_ready", int'(div_ready), m_pend ? 0 : 1);
`ifdef TICK_GEN_BURST_EN
            chk("model_burst_done", int'(burst_done), int'(m_bdone));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!en && n < maxc);
    endtask

    task automatic count_en(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            step();
            if (en) c++;
        end
    endtask

    task automatic load_div(input int v);
        div_in = W'(v); div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        int n;
        int c;
        int last;
        int pulses;

        repeat (3) step();
        chk("reset_en", int'(en), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_ready", int'(div_ready), 1);
        r = 1'b1;
        step();

        // Period: DIV=4, 48 cycles after a one-cycle start
        pulse_start();
        last = 0; pulses = 0;
        for (int i = 1; i <= 48; i++) begin
            step();
            if (en) begin
                if (last == 0) chk("period_first", i, 4);
                else           chk("period_gap", i - last, 4);
                last = i;
                pulses++;
            end
        end
        chk("period_count", pulses, 12);

        // Asynchronous reset while en is high
        chk("pre_reset_en", int'(en), 1);
        r = 1'b0;
        #1;
        chk("async_en", int'(en), 0);
        chk("async_running", int'(running), 0);
        chk("async_ready", int'(div_ready), 1);
        #2;
        r = 1'b1;
        pulse_start();
        wait_en(20, n);
        chk("reset_first_tick", n, 4);

        // Hold/resume with DIV=5, stop sampled while cnt=2
        do_clr();
        load_div(5);
        pulse_start();
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("hold_running", int'(running), 0);
        count_en(7, c);
        chk("hold_no_tick", c, 0);
        pulse_start();
        wait_en(20, n);
        chk("resume_tick", n, 3);

        // Divisor load in RUN: 4 -> 2
        do_clr();
        load_div(4);
        pulse_start();
        wait_en(20, n);
        chk("div4_first", n, 4);
        step();
        load_div(2);
        chk("ready_low", int'(div_ready), 0);
        wait_en(20, n);
        chk("load_tick", n, 2);
        chk("ready_back", int'(div_ready), 1);
        wait_en(20, n);
        chk("new_period_a", n, 2);
        wait_en(20, n);
        chk("new_period_b", n, 2);

        // Divisor 0 ticks every cycle
        do_clr();
        load_div(0);
        pulse_start();
        count_en(5, c);
        chk("div0_every_cycle", c, 5);

        // start and stop together: RUN -> HOLD, IDLE stays IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_run", int'(running), 0);
        count_en(3, c);
        chk("startstop_no_tick", c, 0);
        do_clr();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_idle", int'(running), 0);

        // clr with div_load: load dropped, divisor stays 3
        load_div(3);
        pulse_start();
        step();
        clr = 1'b1; div_in = 8'd6; div_load = 1'b1;
        step();
        clr = 1'b0; div_load = 1'b0;
        chk("clr_load_idle", int'(running), 0);
        chk("clr_load_ready", int'(div_ready), 1);
        pulse_start();
        wait_en(20, n);
        chk("clr_load_div", n, 3);

`ifdef TICK_GEN_BURST_EN
        // Burst of 3 with DIV=2
        do_clr();
        load_div(2);
        burst_len = 8'd3;
        pulse_start();
        begin
            int ticks;
            int dones;
            int third_at;
            int done_at;
            ticks = 0; dones = 0; third_at = -1; done_at = -2;
            for (int i = 1; i <= 12; i++) begin
                step();
                if (en) begin
                    ticks++;
                    if (ticks == 3) third_at = i;
                end
                if (burst_done) begin
                    dones++;
                    done_at = i;
                end
            end
            chk("burst_ticks", ticks, 3);
            chk("burst_done_count", dones, 1);
            chk("burst_done_with_third", done_at, third_at);
            chk("burst_third_at", third_at, 6);
            chk("burst_running_after", int'(running), 0);
        end
        burst_len = '0;
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
